// File: rtl/sinusoid_seq_pkg.sv
// ============================================================================
// Module   : sinusoid_seq_pkg
// Purpose  : Shared types, constants and the phase-accumulator helper for the
//            sinusoid phase sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sinusoid_seq_pkg;

  // Width of the completed-period counter.
  localparam int unsigned c_wrap_w = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        wrap;
  } phase_next_t;

  // Advance a LUT index by step, modulo depth. Both operands are below depth,
  // so a single conditional subtract is sufficient and the 32-bit sum cannot
  // overflow.
  function automatic phase_next_t phase_wrap(input logic [31:0] addr,
                                             input logic [31:0] step,
                                             input logic [31:0] depth);
    phase_next_t r;
    logic [31:0] sum;
    sum = addr + step;
    if (sum >= depth) begin
      r.addr = sum - depth;
      r.wrap = 1'b1;
    end else begin
      r.addr = sum;
      r.wrap = 1'b0;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sinusoid.sv
// ============================================================================
// Module   : sinusoid
// Purpose  : Combinational one-period sine lookup table. Entry i holds
//            round(sin(2*pi*i/depth_p) * (2^(width_p-1)-1)). Indices at or
//            beyond depth_p read as zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sinusoid #(
  parameter int depth_p = 100,
  parameter int width_p = 12
) (
  input  logic [$clog2(depth_p)-1:0] rd_addr_i,
  output logic signed [width_p-1:0]  data_o
);

  localparam int unsigned     c_aw    = $clog2(depth_p);
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(depth_p);

  // Elaboration-time sine in Q30 fixed point: fold the angle into
  // [-pi/2, pi/2] and sum a Taylor series up to x^17.
  function automatic logic signed [width_p-1:0] sine_entry(input int idx);
    longint pi_q;
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint amp;
    longint r;
    pi_q = 64'sd3373259426;
    x    = (64'sd2 * pi_q * longint'(idx)) / longint'(depth_p);
    if (x > pi_q) x = x - 64'sd2 * pi_q;
    if (x > pi_q / 64'sd2)
      x = pi_q - x;
    else if (x < -(pi_q / 64'sd2))
      x = -pi_q - x;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    amp = (64'sd1 <<< (width_p - 1)) - 64'sd1;
    r   = (acc * amp + (64'sd1 <<< 29)) >>> 30;
    return width_p'(r);
  endfunction

  logic signed [width_p-1:0] w_lut [0:depth_p-1];

  for (genvar g = 0; g < depth_p; g++) begin : g_lut
    localparam logic signed [width_p-1:0] c_val = sine_entry(g);
    assign w_lut[g] = c_val;
  end

  // Read port with out-of-range guard for non power-of-two depths.
  always_comb begin
    data_o = '0;
    if ({1'b0, rd_addr_i} < c_depth) data_o = w_lut[rd_addr_i];
  end

endmodule

`default_nettype wire

// File: rtl/sinusoid_seq.sv
// ============================================================================
// Module   : sinusoid_seq
// Purpose  : Phase sequencer around the sinusoid LUT. Steps the read address
//            by a programmable increment modulo depth_p, paces captures with a
//            rate divider and presents registered samples on a valid/ready
//            stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sinusoid_seq
  import sinusoid_seq_pkg::*;
#(
  parameter int depth_p     = 100,
  parameter int width_p     = 12,
  parameter int div_width_p = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [$clog2(depth_p)-1:0] step_i,
  input  logic [$clog2(depth_p)-1:0] phase_i,
  input  logic [div_width_p-1:0]     div_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic signed [width_p-1:0]  data_o,
  output logic                       busy_o,
  output logic [c_wrap_w-1:0]        wrap_count_o
);

  localparam int unsigned   c_aw    = $clog2(depth_p);
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(depth_p);

  state_e                    state_q,   state_d;
  logic [c_aw-1:0]           addr_q,    addr_d;
  logic [c_aw-1:0]           step_q,    step_d;
  logic [div_width_p-1:0]    div_q,     div_d;
  logic [div_width_p-1:0]    div_cnt_q, div_cnt_d;
  logic                      valid_q,   valid_d;
  logic signed [width_p-1:0] data_q,    data_d;
  logic [c_wrap_w-1:0]       wrap_q,    wrap_d;

  logic signed [width_p-1:0] w_lut_data;
  phase_next_t               w_nxt;
  logic                      w_unused_addr_hi;
  logic                      w_hs;
  logic                      w_capture;
  logic                      w_accept;

  sinusoid #(
    .depth_p (depth_p),
    .width_p (width_p)
  ) u_lut (
    .rd_addr_i (addr_q),
    .data_o    (w_lut_data)
  );

  assign w_nxt            = phase_wrap(32'(addr_q), 32'(step_q), 32'(depth_p));
  assign w_unused_addr_hi = ^w_nxt.addr[31:c_aw];
  assign w_hs             = valid_q & ready_i;
  // A capture needs the divider expired and the output slot free or draining.
  assign w_capture        = (div_cnt_q == '0) & (~valid_q | ready_i);
  assign w_accept         = (state_q == ST_IDLE) & start_i & ~stop_i;

  // State and datapath registers; reset drops any pending sample at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      step_q    <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      wrap_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      step_q    <= step_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      wrap_q    <= wrap_d;
    end
  end

  // Next-state logic: configuration latch, paced capture and drain.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    step_d    = step_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    valid_d   = valid_q;
    data_d    = data_q;
    wrap_d    = wrap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          step_d    = step_i;
          div_d     = div_i;
          div_cnt_d = div_i;
          addr_d    = ({1'b0, phase_i} < c_depth) ? phase_i : '0;
          wrap_d    = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          // No capture in the stop cycle; an unaccepted sample must drain.
          if (w_hs) valid_d = 1'b0;
          state_d = (valid_q && !w_hs) ? ST_DRAIN : ST_IDLE;
        end else if (w_capture) begin
          data_d    = w_lut_data;
          valid_d   = 1'b1;
          div_cnt_d = div_q;
          addr_d    = w_nxt.addr[c_aw-1:0];
          wrap_d    = wrap_q + {{(c_wrap_w-1){1'b0}}, w_nxt.wrap};
        end else begin
          // Divider runs independently of backpressure; a stall at zero holds.
          if (div_cnt_q != '0) div_cnt_d = div_cnt_q - div_width_p'(1);
          if (w_hs) valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (w_hs) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign wrap_count_o = wrap_q;

  // Phase increments must stay below the table depth.
  a_step_range : assert property (@(posedge clk_i) disable iff (reset_i)
    w_accept |-> ({1'b0, step_i} < c_depth));

endmodule

`default_nettype wire

// File: tb/tb_sinusoid_seq.sv
// ============================================================================
// Module   : tb_sinusoid_seq
// Purpose  : Self-checking bench for sinusoid_seq: table of phase/step/div
//            runs checked through a sample scoreboard, plus hand-written
//            sequences for stalls, drain, ignored starts and async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sinusoid_seq;

  localparam int DEPTH = 100;
  localparam int WIDTH = 12;
  localparam int DIVW  = 16;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    start;
  logic                    stop;
  logic                    ready;
  logic [AW-1:0]           step;
  logic [AW-1:0]           phase;
  logic [DIVW-1:0]         div;
  logic                    valid;
  logic signed [WIDTH-1:0] data;
  logic                    busy;
  logic [15:0]             wrapc;

  sinusoid_seq #(
    .depth_p     (DEPTH),
    .width_p     (WIDTH),
    .div_width_p (DIVW)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .start_i      (start),
    .stop_i       (stop),
    .step_i       (step),
    .phase_i      (phase),
    .div_i        (div),
    .ready_i      (ready),
    .valid_o      (valid),
    .data_o       (data),
    .busy_o       (busy),
    .wrap_count_o (wrapc)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int data;
    int wrap;
  } exp_t;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;
  int   n_pop  = 0;

  typedef struct {
    int ph;
    int st;
    int dv;
    int n;
  } vec_t;
  vec_t vecs[6];

  function automatic int sine_ref(input int a);
    real v;
    v = $sin(2.0 * 3.14159265358979323846 * a / DEPTH) * ((1 << (WIDTH - 1)) - 1);
    return int'($floor(v + 0.5));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected sample stream for a run from (ph, st).
  task automatic push_seq(input int ph, input int st, input int n);
    int a;
    int s;
    int w;
    exp_t e;
    a = (ph < DEPTH) ? ph : 0;
    w = 0;
    for (int k = 0; k < n; k++) begin
      s = a + st;
      if (s >= DEPTH) begin
        s = s - DEPTH;
        w++;
      end
      e.data = sine_ref(a);
      e.wrap = w & 16'hFFFF;
      exp_q.push_back(e);
      a = s;
    end
  endtask

  // Scoreboard: a sample seen with valid & ready is consumed at the next edge.
  always @(negedge clk) begin
    if (mon_en && valid && ready) begin
      exp_t e;
      int   d;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_sample: got data %0d, expected no sample", data);
      end else begin
        e = exp_q.pop_front();
        d = int'(data) - e.data;
        if (d > 1 || d < -1) begin
          n_fail++;
          $display("FAIL sample_data #%0d: got %0d, expected %0d", n_pop, data, e.data);
        end
        n_chk++;
        if (int'(wrapc) != e.wrap) begin
          n_fail++;
          $display("FAIL sample_wrap #%0d: got %0d, expected %0d", n_pop, wrapc, e.wrap);
        end
      end
      n_pop++;
    end
  end

  task automatic do_start(input int ph, input int st, input int dv);
    phase = AW'(ph);
    step  = AW'(st);
    div   = DIVW'(dv);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int c;
    c = 0;
    while (n_pop < target && c < budget) begin
      tick();
      c++;
    end
    check("pop_timeout", (n_pop >= target) ? 1 : 0, 1);
  endtask

  task automatic finish_run();
    mon_en = 1'b0;
    stop   = 1'b1;
    tick();
    stop   = 1'b0;
    check("stop_idle_busy", int'(busy), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0]             mask;
    logic signed [WIDTH-1:0] held_data;
    logic [AW-1:0]           held_addr;
    int                      bad;
    int                      lat;

    vecs[0] = '{ph: 0,   st: 1,  dv: 0, n: 101};
    vecs[1] = '{ph: 95,  st: 7,  dv: 0, n: 4};
    vecs[2] = '{ph: 120, st: 3,  dv: 0, n: 3};
    vecs[3] = '{ph: 10,  st: 0,  dv: 1, n: 5};
    vecs[4] = '{ph: 50,  st: 33, dv: 2, n: 6};
    vecs[5] = '{ph: 99,  st: 99, dv: 0, n: 5};

    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    ready = 1'b0;
    step  = '0;
    phase = '0;
    div   = '0;
    tick();
    tick();
    check("reset_valid", int'(valid), 0);
    check("reset_data",  int'(data),  0);
    check("reset_busy",  int'(busy),  0);
    check("reset_wrap",  int'(wrapc), 0);
    rst = 1'b0;
    tick();

    // Table-driven runs with free-flowing downstream.
    for (int v = 0; v < 6; v++) begin
      exp_q.delete();
      push_seq(vecs[v].ph, vecs[v].st, vecs[v].n);
      n_pop  = 0;
      mon_en = 1'b1;
      ready  = 1'b1;
      do_start(vecs[v].ph, vecs[v].st, vecs[v].dv);
      check("run_busy", int'(busy), 1);
      lat = 0;
      while (!valid && lat < 50) begin
        tick();
        lat++;
      end
      check("first_latency", lat, vecs[v].dv + 1);
      wait_pops(vecs[v].n, vecs[v].n * (vecs[v].dv + 1) + 20);
      finish_run();
    end

    // Divider pacing, 10-cycle stall, then back-to-back capture on release.
    exp_q.delete();
    push_seq(0, 1, 8);
    n_pop  = 0;
    mon_en = 1'b1;
    ready  = 1'b1;
    do_start(0, 1, 3);
    mask = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      mask[k] = valid;
    end
    check("div3_pattern", int'(mask), int'(16'b1000_1000_1000_1000));
    ready     = 1'b0;
    held_data = data;
    held_addr = dut.addr_q;
    bad       = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!valid || data != held_data || dut.addr_q != held_addr) bad++;
    end
    check("stall_hold", bad, 0);
    ready = 1'b1;
    tick();
    check("b2b_valid", int'(valid), 1);
    wait_pops(8, 60);
    finish_run();

    // Stop while a sample is stalled: drain until the handshake.
    exp_q.delete();
    push_seq(10, 3, 1);
    n_pop  = 0;
    mon_en = 1'b1;
    ready  = 1'b0;
    do_start(10, 3, 0);
    tick();
    check("drain_pre_valid", int'(valid), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("drain_busy", int'(busy), 1);
    tick();
    tick();
    tick();
    check("drain_busy_hold", int'(busy), 1);
    check("drain_valid_hold", int'(valid), 1);
    ready = 1'b1;
    tick();
    check("drain_done_busy", int'(busy), 0);
    check("drain_done_valid", int'(valid), 0);
    check("drain_pops", n_pop, 1);
    tick();
    tick();
    check("drain_no_extra", int'(valid), 0);
    mon_en = 1'b0;

    // Stop with nothing pending returns to IDLE at the next edge.
    ready = 1'b1;
    do_start(0, 1, 5);
    check("stop_nv_pre_busy", int'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_nv_busy", int'(busy), 0);
    check("stop_nv_valid", int'(valid), 0);

    // Start and stop together in IDLE are refused.
    phase = '0;
    step  = AW'(1);
    div   = '0;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_idle", int'(busy), 0);
    tick();
    check("start_stop_valid", int'(valid), 0);

    // A start pulse during RUN must not reload step or phase.
    exp_q.delete();
    push_seq(0, 1, 10);
    n_pop  = 0;
    mon_en = 1'b1;
    ready  = 1'b1;
    do_start(0, 1, 0);
    tick();
    tick();
    tick();
    phase = AW'(50);
    step  = AW'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pops(10, 40);
    finish_run();

    // Asynchronous reset while a sample is stalled.
    exp_q.delete();
    push_seq(95, 7, 2);
    n_pop  = 0;
    mon_en = 1'b1;
    ready  = 1'b1;
    do_start(95, 7, 0);
    wait_pops(2, 20);
    ready  = 1'b0;
    mon_en = 1'b0;
    check("pre_reset_valid", int'(valid), 1);
    check("pre_reset_wrap", int'(wrapc), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", int'(valid), 0);
    check("async_rst_busy",  int'(busy),  0);
    check("async_rst_wrap",  int'(wrapc), 0);
    tick();
    tick();
    rst   = 1'b0;
    ready = 1'b1;
    bad   = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (valid || busy) bad++;
    end
    check("post_reset_quiet", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sinusoid_seq.md
Name: sinusoid_seq

Overview:
Phase sequencer for the sinusoid lookup block. It instantiates sinusoid and steps its read address by a programmable phase increment, modulo depth_p. It paces samples with a programmable rate divider and presents registered samples on a valid/ready stream. It sits between the control registers and the downstream DAC/PWM or stream consumer.

Parameters:
depth_p, 100, LUT entries per period (need not be a power of 2)
width_p, 12, sample width (signed)
div_width_p, 16, width of the rate-divider value

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; asynchronous, active-high
start_i  in  1  start pulse; sampled only in IDLE
stop_i  in  1  stop request; sampled in RUN
step_i  in  $clog2(depth_p)  phase increment; latched on accepted start
phase_i  in  $clog2(depth_p)  initial LUT index; latched on accepted start
div_i  in  div_width_p  rate divider; one sample per div_i+1 cycles when unstalled
ready_i  in  1  downstream ready
valid_o  out  1  sample valid
data_o  out  signed width_p  sample
busy_o  out  1  state != IDLE
wrap_count_o  out  16  count of completed periods; rolls over modulo 2^16

Behaviour:
- Reset (async): state IDLE; valid_o=0, data_o=0, addr=0, step=0, div=0, div_cnt=0, wrap_count_o=0. Reset mid-operation drops any pending sample immediately.
- States:
  - IDLE: on start_i=1 and stop_i=0, latch step, div, and addr. addr = phase_i if phase_i < depth_p, else 0. Set div_cnt=div and wrap_count_o=0, then go to RUN. If start_i and stop_i are both high, stay in IDLE.
  - RUN: runs the capture logic below. On stop_i, go to DRAIN if valid_o=1 and no handshake occurs this cycle, else go to IDLE. No capture happens in the stop cycle.
  - DRAIN: no captures. Hold the sample until valid_o & ready_i, then go to IDLE. start_i is ignored while busy.
- Capture rule in RUN:
  - A capture fires at an edge where div_cnt==0 and (valid_o==0 or ready_i==1).
  - On capture:
    - data_o <= LUT[addr] (the combinational sinusoid read is registered here); valid_o <= 1.
    - div_cnt <= div.
    - addr <= next_addr, where next_addr = addr+step if that sum < depth_p, else addr+step-depth_p. The sum is computed at $clog2(depth_p)+1 bits.
    - wrap_count_o increments when the sum >= depth_p.
  - If div_cnt!=0, div_cnt decrements regardless of ready_i.
  - If div_cnt==0 and valid_o & !ready_i (stall), div_cnt stays 0 and addr and data_o hold.
  - On a handshake (valid_o & ready_i) with no capture in the same edge, valid_o <= 0. data_o holds its last value.
- Latency: a start accepted at edge E0 with div=0 gives the first valid_o after E1. With ready_i held high, samples appear back-to-back every div+1 cycles.
- data_o and addr are stable while valid_o=1 and ready_i=0 (AXI-style stream rule).
- step=0 is legal: constant output, wrap_count_o never increments.
- step_i values >= depth_p are outside the contract; the RTL asserts step < depth_p in simulation.

Decomposition:
- Package sinusoid_seq_pkg: state enum (IDLE, RUN, DRAIN) and the wrap-counter width constant (16).
- Instantiate the existing sinusoid block with depth_p and width_p passed through, and rd_addr_i driven from addr.
- A small combinational helper function in the package, phase_wrap(addr, step, depth), returns the next address and the wrap flag. No further sub-modules.

Test Plan:
1. Reset mid-RUN with valid_o=1 and ready_i=0 -> valid_o=0, busy_o=0, and wrap_count_o=0 immediately; no sample emitted after release.
2. depth 100, start with phase_i=0, step_i=1, div_i=0, ready_i=1 -> valid_o every cycle from E1; addresses 0,1,...,99,0; wrap_count_o=1 right after the index-99 capture; data matches sine.hex entries.
3. phase_i=95, step_i=7 -> address sequence 95,2,9,16; wrap_count_o increments exactly once, at the 95->2 capture.
4. div_i=3, ready_i=1 -> valid_o pulses one cycle in every 4. Then hold ready_i=0 for 10 cycles -> data_o is frozen and addr does not advance; on ready_i=1 the next sample is captured the same edge (back-to-back).
5. stop_i while a sample is stalled -> busy_o stays 1 in DRAIN until ready_i; IDLE the cycle after the handshake; no extra capture. stop_i with valid_o=0 -> IDLE next edge.
6. start_i and stop_i both high in IDLE -> stays IDLE. start_i during RUN with new step_i -> ignored; step unchanged. phase_i=120 -> first sample address 0.
